// File: rtl/clock_divider.sv
// Divides clkIN by VALUE, emitting a one-cycle registered strobe.
// Counting restarts from zero whenever nResetIN is asserted.
module clock_divider #(
  parameter int VALUE = 5
) (
  input  logic clkIN,
  input  logic nResetIN,
  output logic clkOUT
);

  localparam int W = (VALUE > 1) ? $clog2(VALUE) : 1;
  localparam logic [W-1:0] LAST = W'(VALUE - 1);

  if (VALUE < 1) begin : gBadValue
    $fatal(1, "clock_divider: VALUE must be >= 1");
  end

  logic [W-1:0] cnt;

  // Wrap explicitly at LAST so non-power-of-two ratios never overflow.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      cnt    <= '0;
      clkOUT <= 1'b0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      clkOUT <= 1'b1;
    end else begin
      cnt    <= cnt + W'(1);
      clkOUT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider at ratios 5, 1 and 4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_clock_divider;

  logic clk;
  logic rst5, rst1, rst4;
  logic out5, out1, out4;

  int checks = 0;
  int errors = 0;

  clock_divider #(.VALUE(5)) dut5 (
    .clkIN(clk), .nResetIN(rst5), .clkOUT(out5)
  );
  clock_divider #(.VALUE(1)) dut1 (
    .clkIN(clk), .nResetIN(rst1), .clkOUT(out1)
  );
  clock_divider #(.VALUE(4)) dut4 (
    .clkIN(clk), .nResetIN(rst4), .clkOUT(out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edgeWait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 50; i++) begin
      edgeWait();
      checks++;
      if (out5 !== 1'b0 || out1 !== 1'b0 || out4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold edge %0d: got %b%b%b need 000",
                 i, out5, out1, out4);
      end
    end
  endtask

  task automatic test_period5();
    logic exp;
    @(negedge clk);
    rst5 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      edgeWait();
      exp = (i % 5 == 0);
      checks++;
      if (out5 !== exp) begin
        errors++;
        $display("FAIL period5 edge %0d: got %b need %b", i, out5, exp);
      end
    end
    @(negedge clk);
    rst5 = 1'b0;
  endtask

  task automatic test_midcount_reset();
    logic exp;
    @(negedge clk);
    rst5 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edgeWait();
      checks++;
      if (out5 !== 1'b0) begin
        errors++;
        $display("FAIL midcount_pre edge %0d: got %b need 0", i, out5);
      end
    end
    rst5 = 1'b0;
    #1;
    checks++;
    if (out5 !== 1'b0) begin
      errors++;
      $display("FAIL midcount_assert: got %b need 0", out5);
    end
    edgeWait();
    edgeWait();
    @(negedge clk);
    rst5 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      edgeWait();
      exp = (i % 5 == 0);
      checks++;
      if (out5 !== exp) begin
        errors++;
        $display("FAIL midcount_restart edge %0d: got %b need %b",
                 i, out5, exp);
      end
    end
    @(negedge clk);
    rst5 = 1'b0;
  endtask

  task automatic test_reset_while_high();
    @(negedge clk);
    rst5 = 1'b1;
    repeat (5) edgeWait();
    checks++;
    if (out5 !== 1'b1) begin
      errors++;
      $display("FAIL high_before_reset: got %b need 1", out5);
    end
    rst5 = 1'b0;
    #1;
    checks++;
    if (out5 !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: got %b need 0", out5);
    end
  endtask

  task automatic test_value1();
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    checks++;
    if (out1 !== 1'b0) begin
      errors++;
      $display("FAIL v1_before_edge: got %b need 0", out1);
    end
    for (int i = 1; i <= 8; i++) begin
      edgeWait();
      checks++;
      if (out1 !== 1'b1) begin
        errors++;
        $display("FAIL v1_high edge %0d: got %b need 1", i, out1);
      end
    end
    #1;
    rst1 = 1'b0;
    #1;
    checks++;
    if (out1 !== 1'b0) begin
      errors++;
      $display("FAIL v1_async_drop: got %b need 0", out1);
    end
  endtask

  task automatic test_value4();
    int pulses = 0;
    int lastRise = 0;
    logic prev = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      edgeWait();
      checks++;
      if (dut4.cnt > 2'd3) begin
        errors++;
        $display("FAIL v4_cnt edge %0d: got %0d need <=3", i, dut4.cnt);
      end
      if (out4 === 1'b1 && prev !== 1'b1) begin
        pulses++;
        if (lastRise != 0) begin
          checks++;
          if (i - lastRise != 4) begin
            errors++;
            $display("FAIL v4_interval edge %0d: got %0d need 4",
                     i, i - lastRise);
          end
        end
        lastRise = i;
      end
      prev = out4;
    end
    checks++;
    if (pulses != 25) begin
      errors++;
      $display("FAIL v4_pulses: got %0d need 25", pulses);
    end
    checks++;
    if (lastRise != 100) begin
      errors++;
      $display("FAIL v4_last_rise: got %0d need 100", lastRise);
    end
    @(negedge clk);
    rst4 = 1'b0;
  endtask

  initial begin
    rst5 = 1'b0;
    rst1 = 1'b0;
    rst4 = 1'b0;
    test_reset();
    test_period5();
    test_midcount_reset();
    test_reset_while_high();
    test_value1();
    test_value4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
